// File: rtl/javk_bus_ctrl_pkg.sv
// Shared definitions for the JAVK external memory bus sequencer.
//   Requester indices, FSM state encoding, starvation limit and the
//   address increment helper used for the second byte of a word transfer.
package javk_bus_ctrl_pkg;

  localparam int NREQ       = 3;
  localparam int AW         = 16;
  localparam int STARVE_MAX = 2;
  localparam int SCW        = $clog2(STARVE_MAX + 1);

  localparam int REQ_FETCH  = 0;
  localparam int REQ_DATA   = 1;
  localparam int REQ_STACK  = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BYTE0 = 2'd1,
    ST_BYTE1 = 2'd2
  } state_t;

  // Wraps 0xFFFF to 0x0000 by construction (AW-bit result).
  function automatic logic [AW-1:0] addr_inc(input logic [AW-1:0] a);
    return a + AW'(1);
  endfunction

endpackage

// File: rtl/javk_bus_ctrl_if.sv
// Bundle of the requester handshake and external byte-bus signals.
//   req/req_addr/req_wr/req_word/req_wdata : core requesters -> controller
//   ack/rdata                              : controller -> core requesters
//   bus_addr/bus_we/bus_wdata              : controller -> top-level pins
//   bus_rdata                              : databus -> controller
//   busy                                   : controller status
// slave = the controller, master = the core/pin side.
interface javk_bus_ctrl_if;
  import javk_bus_ctrl_pkg::*;

  logic [NREQ-1:0]    req;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ-1:0]    req_wr;
  logic [NREQ-1:0]    req_word;
  logic [NREQ*16-1:0] req_wdata;
  logic [NREQ-1:0]    ack;
  logic [15:0]        rdata;
  logic [AW-1:0]      bus_addr;
  logic               bus_we;
  logic [7:0]         bus_wdata;
  logic [7:0]         bus_rdata;
  logic               busy;

  modport slave (
    input  req, req_addr, req_wr, req_word, req_wdata, bus_rdata,
    output ack, rdata, bus_addr, bus_we, bus_wdata, busy
  );

  modport master (
    output req, req_addr, req_wr, req_word, req_wdata, bus_rdata,
    input  ack, rdata, bus_addr, bus_we, bus_wdata, busy
  );
endinterface

// File: rtl/javk_bus_ctrl_arb.sv
// Requester arbiter for the JAVK bus.
//   clk, rst : clock, async active-high reset
//   arb_en   : this edge is an arbitration edge (IDLE or completion)
//   req      : raw requests
//   mask     : requester completing at this edge (excluded from the pick)
//   grant    : one-hot winner, all zero when arb_en is low or nothing eligible
// Fixed priority STACK > DATA > FETCH, with FETCH promoted once it has
// watched STARVE_MAX non-fetch grants go by while requesting.
module javk_bus_ctrl_arb
  import javk_bus_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            arb_en,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] mask,
  output logic [NREQ-1:0] grant
);

  logic [SCW-1:0]  starve_cnt;
  logic [NREQ-1:0] elig;

  always_comb begin
    elig  = req & ~mask;
    grant = '0;
    if (arb_en) begin
      if (starve_cnt == SCW'(STARVE_MAX) && elig[REQ_FETCH]) grant[REQ_FETCH] = 1'b1;
      else if (elig[REQ_STACK])                              grant[REQ_STACK] = 1'b1;
      else if (elig[REQ_DATA])                               grant[REQ_DATA]  = 1'b1;
      else if (elig[REQ_FETCH])                              grant[REQ_FETCH] = 1'b1;
    end
  end

  // Counts against the raw fetch request, so a fetch that is merely masked
  // at its own completion edge still sees the next grant as a pass-over.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (arb_en) begin
      if (!req[REQ_FETCH] || grant[REQ_FETCH])
        starve_cnt <= '0;
      else if ((grant != '0) && (starve_cnt != SCW'(STARVE_MAX)))
        starve_cnt <= starve_cnt + SCW'(1);
    end
  end

endmodule

// File: rtl/javk_bus_ctrl.sv
// JAVK external memory bus sequencer.
//   clk, rst : clock, async active-high reset
//   bif      : requester handshake + external byte bus (slave modport)
// Latches the granted request, runs one or two byte cycles (low byte first),
// assembles read data and pulses ack for the cycle after completion.
//
// state    | meaning
// ---------+-------------------------------------------------
// ST_IDLE  | no transfer, bus_we low, bus_addr holds
// ST_BYTE0 | addr / low byte on the bus
// ST_BYTE1 | addr+1 / high byte on the bus (word only)
module javk_bus_ctrl
  import javk_bus_ctrl_pkg::*;
(
  input logic            clk,
  input logic            rst,
  javk_bus_ctrl_if.slave bif
);

  state_t          state, state_nxt;
  logic [AW-1:0]   cur_addr;
  logic            cur_wr, cur_word;
  logic [15:0]     cur_wdata;
  logic [NREQ-1:0] cur_id;
  logic [7:0]      rdata_lo;

  logic            complete, arb_en, gnt_any;
  logic [NREQ-1:0] grant, mask;

  logic [AW-1:0]   g_addr;
  logic            g_wr, g_word;
  logic [15:0]     g_wdata;

  assign complete = ((state == ST_BYTE0) && !cur_word) || (state == ST_BYTE1);
  assign arb_en   = (state == ST_IDLE) || complete;
  assign mask     = complete ? cur_id : '0;
  assign gnt_any  = |grant;
  assign bif.busy = (state != ST_IDLE);

  javk_bus_ctrl_arb u_arb (
    .clk    (clk),
    .rst    (rst),
    .arb_en (arb_en),
    .req    (bif.req),
    .mask   (mask),
    .grant  (grant)
  );

  always_comb begin
    g_addr  = '0;
    g_wr    = 1'b0;
    g_word  = 1'b0;
    g_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        g_addr  = bif.req_addr[i*AW +: AW];
        g_wr    = bif.req_wr[i];
        g_word  = bif.req_word[i];
        g_wdata = bif.req_wdata[i*16 +: 16];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (gnt_any) state_nxt = ST_BYTE0;
      ST_BYTE0: if (cur_word) state_nxt = ST_BYTE1;
                else          state_nxt = gnt_any ? ST_BYTE0 : ST_IDLE;
      ST_BYTE1: state_nxt = gnt_any ? ST_BYTE0 : ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      cur_addr      <= '0;
      cur_wr        <= 1'b0;
      cur_word      <= 1'b0;
      cur_wdata     <= '0;
      cur_id        <= '0;
      rdata_lo      <= '0;
      bif.ack       <= '0;
      bif.rdata     <= '0;
      bif.bus_addr  <= '0;
      bif.bus_we    <= 1'b0;
      bif.bus_wdata <= '0;
    end else begin
      state   <= state_nxt;
      bif.ack <= '0;

      if (complete) begin
        bif.ack <= cur_id;
        if (!cur_wr)
          bif.rdata <= cur_word ? {bif.bus_rdata, rdata_lo} : {8'h00, bif.bus_rdata};
      end

      if ((state == ST_BYTE0) && cur_word) begin
        rdata_lo      <= bif.bus_rdata;
        bif.bus_addr  <= addr_inc(cur_addr);
        bif.bus_wdata <= cur_wdata[15:8];
      end

      // A grant at a completion edge overrides the end-of-transfer update,
      // which is what makes back-to-back transfers bubble-free.
      if (gnt_any) begin
        cur_addr      <= g_addr;
        cur_wr        <= g_wr;
        cur_word      <= g_word;
        cur_wdata     <= g_wdata;
        cur_id        <= grant;
        bif.bus_addr  <= g_addr;
        bif.bus_we    <= g_wr;
        bif.bus_wdata <= g_wdata[7:0];
      end else if (complete) begin
        bif.bus_we <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_javk_bus_ctrl.sv
module tb_javk_bus_ctrl;
  import javk_bus_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  javk_bus_ctrl_if bif();
  javk_bus_ctrl dut (.clk(clk), .rst(rst), .bif(bif));

  // external memory seen by the DUT, plus preload port
  bit   [7:0]  mem [0:65535];
  logic        pre_we;
  logic [15:0] pre_a;
  logic [7:0]  pre_d;
  assign bif.bus_rdata = mem[bif.bus_addr];
  always @(posedge clk) begin
    if (pre_we) mem[pre_a] = pre_d;
    if (bif.bus_we) mem[bif.bus_addr] = bif.bus_wdata;
  end

  // reference model state
  bit   [7:0]  ref_mem [0:65535];
  int          m_cnt;

  int n_chk = 0, n_pass = 0;

  logic [15:0] cap_addr [4];
  logic [7:0]  cap_wd   [4];
  logic        cap_we   [4];
  int          cap_n;

  logic [15:0] s_addr [3];
  logic        s_wr   [3];
  logic        s_word [3];
  logic [15:0] s_wd   [3];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [15:0] ref_read(input logic [15:0] a, input logic word);
    logic [15:0] a1 = a + 16'd1;
    return word ? {ref_mem[a1], ref_mem[a]} : {8'h00, ref_mem[a]};
  endfunction

  task automatic ref_write(input logic [15:0] a, input logic word, input logic [15:0] d);
    logic [15:0] a1 = a + 16'd1;
    ref_mem[a] = d[7:0];
    if (word) ref_mem[a1] = d[15:8];
  endtask

  // Arbitration rules: promoted fetch, else STACK > DATA > FETCH among
  // pending requesters not completing at this edge.
  task automatic model_grant(input logic [2:0] pend, input int excl, output int w);
    logic [2:0] e = pend;
    if (excl >= 0) e[excl] = 1'b0;
    w = -1;
    if (m_cnt == STARVE_MAX && e[0]) w = 0;
    else if (e[2]) w = 2;
    else if (e[1]) w = 1;
    else if (e[0]) w = 0;
    if (!pend[0] || w == 0) m_cnt = 0;
    else if (w > 0 && m_cnt < STARVE_MAX) m_cnt = m_cnt + 1;
  endtask

  task automatic preload(input logic [15:0] a, input logic [7:0] d);
    pre_we = 1'b1; pre_a = a; pre_d = d;
    ref_mem[a] = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic set_slot(input int i, input logic [15:0] a, input logic wr,
                          input logic word, input logic [15:0] wd);
    s_addr[i] = a; s_wr[i] = wr; s_word[i] = word; s_wd[i] = wd;
    bif.req_addr[i*16 +: 16]  = a;
    bif.req_wr[i]             = wr;
    bif.req_word[i]           = word;
    bif.req_wdata[i*16 +: 16] = wd;
  endtask

  // Single transfer; starts and ends just after a negedge.
  task automatic do_txn(input int id, input logic [15:0] a, input logic wr,
                        input logic word, input logic [15:0] wd,
                        output logic [15:0] rd, output int lat);
    bit got = 0;
    set_slot(id, a, wr, word, wd);
    bif.req[id] = 1'b1;
    lat = 0; cap_n = 0; rd = 'x;
    while (!got && lat < 10) begin
      @(negedge clk);
      lat++;
      if (bif.ack[id]) begin
        got = 1; rd = bif.rdata; bif.req[id] = 1'b0;
      end else if (bif.busy && cap_n < 4) begin
        cap_addr[cap_n] = bif.bus_addr;
        cap_wd[cap_n]   = bif.bus_wdata;
        cap_we[cap_n]   = bif.bus_we;
        cap_n++;
      end
    end
    bif.req[id] = 1'b0;
    chk("txn_ack_seen", 32'(got), 1);
  endtask

  task automatic idle_check(input string tag);
    @(negedge clk);
    chk({tag, "_ack_single"}, 32'(bif.ack), 0);
    chk({tag, "_idle"}, 32'(bif.busy), 0);
    chk({tag, "_we_idle"}, 32'(bif.bus_we), 0);
  endtask

  // All three requesters held high; model predicts grant order and timing.
  task automatic run_stream(input string tag, input int nacks);
    int w, k, got, len;
    m_cnt = 0; got = 0; k = 0;
    bif.req = 3'b111;
    model_grant(3'b111, -1, w);
    for (int cyc = 0; cyc < 200 && got < nacks; cyc++) begin
      @(negedge clk);
      k++;
      len = s_word[w] ? 2 : 1;
      if (k == len + 1) begin
        chk({tag, "_ack"}, 32'(bif.ack), 32'(1) << w);
        if (!s_wr[w]) chk({tag, "_rdata"}, 32'(bif.rdata), 32'(ref_read(s_addr[w], s_word[w])));
        else          ref_write(s_addr[w], s_word[w], s_wd[w]);
        got++;
        model_grant(3'b111, w, w);
        k = 1;
      end else begin
        chk({tag, "_no_ack"}, 32'(bif.ack), 0);
      end
      chk({tag, "_busy"}, 32'(bif.busy), 1);
      chk({tag, "_slot"}, 32'(bif.bus_addr[15:8]), 32'(s_addr[w][15:8]));
      chk({tag, "_starve"}, 32'(dut.u_arb.starve_cnt), 32'(m_cnt));
    end
    chk({tag, "_count"}, 32'(got), 32'(nacks));
    bif.req = 3'b000;
    len = s_word[w] ? 2 : 1;
    for (int j = 1; j <= len; j++) begin
      @(negedge clk);
      if (j == len) chk({tag, "_last_ack"}, 32'(bif.ack), 32'(1) << w);
      else          chk({tag, "_last_no_ack"}, 32'(bif.ack), 0);
    end
    if (!s_wr[w]) chk({tag, "_last_rdata"}, 32'(bif.rdata), 32'(ref_read(s_addr[w], s_word[w])));
    else          ref_write(s_addr[w], s_word[w], s_wd[w]);
    idle_check(tag);
  endtask

  initial begin
    logic [15:0] rd, a, wd;
    logic        wr, word;
    int          lat, id;

    rst = 1'b1;
    pre_we = 1'b0; pre_a = '0; pre_d = '0;
    bif.req = '0; bif.req_addr = '0; bif.req_wr = '0;
    bif.req_word = '0; bif.req_wdata = '0;

    // reset state
    @(negedge clk);
    chk("rst_bus_addr", 32'(bif.bus_addr), 0);
    chk("rst_bus_we", 32'(bif.bus_we), 0);
    chk("rst_bus_wdata", 32'(bif.bus_wdata), 0);
    chk("rst_ack", 32'(bif.ack), 0);
    chk("rst_rdata", 32'(bif.rdata), 0);
    chk("rst_busy", 32'(bif.busy), 0);
    rst = 1'b0;
    @(negedge clk);

    // 1: reset during BYTE1 of a DATA word write
    set_slot(REQ_DATA, 16'h8000, 1'b1, 1'b1, 16'h1234);
    bif.req[REQ_DATA] = 1'b1;
    @(negedge clk);
    chk("t1_byte0_addr", 32'(bif.bus_addr), 32'h8000);
    chk("t1_byte0_wd", 32'(bif.bus_wdata), 32'h34);
    @(negedge clk);
    chk("t1_byte1_addr", 32'(bif.bus_addr), 32'h8001);
    chk("t1_byte1_wd", 32'(bif.bus_wdata), 32'h12);
    rst = 1'b1;
    #1;
    chk("t1_rst_busy", 32'(bif.busy), 0);
    chk("t1_rst_we", 32'(bif.bus_we), 0);
    chk("t1_rst_addr", 32'(bif.bus_addr), 0);
    chk("t1_rst_ack", 32'(bif.ack), 0);
    chk("t1_rst_rdata", 32'(bif.rdata), 0);
    bif.req = '0;
    @(negedge clk);
    rst = 1'b0;
    ref_mem[16'h8000] = 8'h34;  // first byte reached memory before reset
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t1_post_ack", 32'(bif.ack), 0);
      chk("t1_post_busy", 32'(bif.busy), 0);
    end

    // 2: FETCH byte read
    preload(16'h0100, 8'hA5);
    do_txn(REQ_FETCH, 16'h0100, 1'b0, 1'b0, 16'h0, rd, lat);
    chk("t2_lat", 32'(lat), 2);
    chk("t2_cycles", 32'(cap_n), 1);
    chk("t2_addr", 32'(cap_addr[0]), 32'h0100);
    chk("t2_we", 32'(cap_we[0]), 0);
    chk("t2_rdata", 32'(rd), 32'h00A5);
    idle_check("t2");
    chk("t2_addr_hold", 32'(bif.bus_addr), 32'h0100);

    // 3: STACK word read across the 0xFFFF wrap
    preload(16'hFFFF, 8'h34);
    preload(16'h0000, 8'h12);
    do_txn(REQ_STACK, 16'hFFFF, 1'b0, 1'b1, 16'h0, rd, lat);
    chk("t3_lat", 32'(lat), 3);
    chk("t3_addr0", 32'(cap_addr[0]), 32'hFFFF);
    chk("t3_addr1", 32'(cap_addr[1]), 32'h0000);
    chk("t3_rdata", 32'(rd), 32'h1234);
    idle_check("t3");

    // 4: DATA word write then read-back
    do_txn(REQ_DATA, 16'h2000, 1'b1, 1'b1, 16'hBEEF, rd, lat);
    ref_write(16'h2000, 1'b1, 16'hBEEF);
    chk("t4_lat", 32'(lat), 3);
    chk("t4_addr0", 32'(cap_addr[0]), 32'h2000);
    chk("t4_wd0", 32'(cap_wd[0]), 32'hEF);
    chk("t4_we0", 32'(cap_we[0]), 1);
    chk("t4_addr1", 32'(cap_addr[1]), 32'h2001);
    chk("t4_wd1", 32'(cap_wd[1]), 32'hBE);
    chk("t4_we1", 32'(cap_we[1]), 1);
    idle_check("t4");
    do_txn(REQ_FETCH, 16'h2000, 1'b0, 1'b1, 16'h0, rd, lat);
    chk("t4_readback", 32'(rd), 32'hBEEF);
    idle_check("t4rb");

    // 5: all three requesters, byte reads
    preload(16'h0200, 8'h5C);
    preload(16'h0300, 8'hC3);
    set_slot(REQ_FETCH, 16'h0100, 1'b0, 1'b0, 16'h0);
    set_slot(REQ_DATA,  16'h0200, 1'b0, 1'b0, 16'h0);
    set_slot(REQ_STACK, 16'h0300, 1'b0, 1'b0, 16'h0);
    run_stream("t5", 9);

    // 6: STACK/DATA word writes hogging the bus, FETCH byte read pending
    set_slot(REQ_FETCH, 16'h0100, 1'b0, 1'b0, 16'h0);
    set_slot(REQ_DATA,  16'h0200, 1'b1, 1'b1, 16'hD00D);
    set_slot(REQ_STACK, 16'h0300, 1'b1, 1'b1, 16'h5A7C);
    run_stream("t6", 9);
    do_txn(REQ_FETCH, 16'h0300, 1'b0, 1'b1, 16'h0, rd, lat);
    chk("t6_stack_mem", 32'(rd), 32'h5A7C);
    idle_check("t6rb");

    // randomized single transfers against the reference memory
    for (int n = 0; n < 40; n++) begin
      id   = int'($urandom_range(0, 2));
      a    = ($urandom_range(0, 7) == 0) ? 16'hFFFF : {8'h40, 8'($urandom_range(0, 31))};
      wr   = 1'($urandom);
      word = 1'($urandom);
      wd   = 16'($urandom);
      do_txn(id, a, wr, word, wd, rd, lat);
      chk("rnd_lat", 32'(lat), word ? 3 : 2);
      chk("rnd_addr0", 32'(cap_addr[0]), 32'(a));
      chk("rnd_we0", 32'(cap_we[0]), 32'(wr));
      if (word) chk("rnd_addr1", 32'(cap_addr[1]), 32'(16'(a + 16'd1)));
      if (wr) begin
        chk("rnd_wd0", 32'(cap_wd[0]), 32'(wd[7:0]));
        if (word) chk("rnd_wd1", 32'(cap_wd[1]), 32'(wd[15:8]));
        ref_write(a, word, wd);
      end else begin
        chk("rnd_rdata", 32'(rd), 32'(ref_read(a, word)));
      end
      idle_check("rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
